i2c_bus_arbiter: RTL
====================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd1023, meaning the maximum cycles allowed in WAIT_START plus WAIT_STOP before the transaction aborts.
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port req0/req1, input, 1 each, a level request from requester 0/1.
REQ-005 The block SHALL have port rnw0/rnw1, input, 1 each, requester read(1)/write(0).
REQ-006 The block SHALL have port addr0/addr1, input, 7 each, requester I2C address.
REQ-007 The block SHALL have port wr_data0/wr_data1, input, 16 each, requester write data.
REQ-008 The block SHALL have port grant0/grant1, output, 1 each, high while that requester owns the bus.
REQ-009 The block SHALL have port done0/done1, output, 1 each, a one-cycle completion pulse.
REQ-010 The block SHALL have port err, output, 1, valid with doneX; 1 means timeout.
REQ-011 The block SHALL have port rd_data, output, 16, read result, valid with doneX.
REQ-012 The block SHALL have port gen_start_stb, output, 1, the start strobe to the transaction generator.
REQ-013 The block SHALL have ports gen_rnw, gen_i2c_addr[6:0] and gen_wr_data[15:0], outputs, the latched fields of the granted request.
REQ-014 The block SHALL have ports gen_scl, gen_sda_out and gen_sda_oe, inputs, 1 each, the generator bus outputs.
REQ-015 The block SHALL have port gen_rd_data, input, 16, the generator read data.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_START, WAIT_STOP and DONE.
REQ-017 In IDLE with any reqX high, the block SHALL pick the winner, set grantX, latch rnwX/addrX/wr_dataX into the gen_* registers, and go to ISSUE.
REQ-018 When both requests are high, the block SHALL grant the requester not served last (last_id toggles round-robin); a single request always wins.
REQ-019 ISSUE SHALL last one cycle with gen_start_stb=1, then go to WAIT_START.
REQ-020 START detect SHALL be: gen_sda_oe=1, gen_scl=1, and gen_sda_out falling versus its one-cycle-delayed copy.
REQ-021 WAIT_START SHALL go to WAIT_STOP on START detect.
REQ-022 STOP detect SHALL be: gen_sda_oe=1, gen_scl=1, and gen_sda_out rising versus its delayed copy.
REQ-023 WAIT_STOP SHALL go to DONE on STOP detect; a STOP in WAIT_START is ignored.
REQ-024 The timeout counter SHALL clear in ISSUE and increment in WAIT_START and WAIT_STOP.
REQ-025 When the timeout counter equals TIMEOUT_CYCLES, the block SHALL go to DONE with err=1.
REQ-026 If STOP detect and timeout occur in the same cycle, STOP SHALL win and err=0.
REQ-027 In DONE, the block SHALL pulse doneX for one cycle, capture gen_rd_data into rd_data (unchanged on writes), drop grantX, update last_id, and return to IDLE.
REQ-028 After DONE, the block SHALL spend at least one cycle in IDLE before re-arbitrating.
REQ-029 gen_* outputs SHALL hold stable from ISSUE through DONE; requester inputs SHALL be ignored after latch.
REQ-030 A requester deasserting reqX mid-transaction SHALL NOT abort it; doneX still pulses.
REQ-031 grant0 and grant1 SHALL never be high simultaneously.

Reset
REQ-032 rst low SHALL asynchronously force: state=IDLE, grantX=0, doneX=0, err=0, rd_data=0, gen_start_stb=0, gen_rnw=0, gen_i2c_addr=0, gen_wr_data=0, last_id=1 (requester 0 wins first), timeout counter=0, and delayed sda=1.
REQ-033 Reset mid-transaction SHALL return the block to IDLE with no doneX pulse.

Structure
REQ-034 State encodings and the TIMEOUT_CYCLES default SHALL live in shared package i2c_pkg.
REQ-035 The round-robin picker SHALL be sub-module i2c_rr_picker (req0, req1, last_id -> winner id, valid).

Verification
REQ-036 req0 only, rnw0=0, addr0=7'h50, wr_data0=16'hA5C3, with the generator model -> grant0 and one gen_start_stb pulse; gen_i2c_addr=7'h50; done0 after STOP; err=0.
REQ-037 req0 and req1 asserted in the same cycle after reset -> requester 0 served first; requester 1 granted on the next arbitration; never both grants.
REQ-038 Read with rnw1=1, slave returning 16'h1234 -> done1 pulse with rd_data=16'h1234.
REQ-039 Slave never ACKs (no STOP), TIMEOUT_CYCLES=64 -> done pulse 64 cycles after entering WAIT_START; err=1.
REQ-040 rst asserted in WAIT_STOP -> all outputs at reset values immediately; no done pulse; the next req0 starts cleanly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus arbiter.
//   arb_state_e     : arbiter FSM state encoding
//   TIMEOUT_DEFAULT : default cycle budget for WAIT_START plus WAIT_STOP
package i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitStart,
      StWaitStop,
      StDone
   } arb_state_e;

   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1023;

endpackage

// File: rtl/i2c_rr_picker.sv
// Two-way round-robin picker.
//   req0, req1 : level requests
//   last_id    : requester served most recently
//   winner     : id of the requester to grant (meaningful when valid)
//   valid      : at least one request is pending
module i2c_rr_picker (
   input  logic req0,
   input  logic req1,
   input  logic last_id,
   output logic winner,
   output logic valid
);

   always_comb begin
      valid = req0 | req1;
      // Contention goes to whoever was not served last; a lone request always wins.
      if (req0 && req1) begin
         winner = ~last_id;
      end else begin
         winner = req1;
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Arbitrates two requesters onto one I2C transaction generator.
//   clk, rst                      : clock, asynchronous active-low reset
//   req/rnw/addr/wr_data 0 and 1  : requester transaction requests
//   grant0/1, done0/1, err        : ownership, completion pulse, timeout flag
//   rd_data                       : read result, valid with done
//   gen_start_stb, gen_rnw,
//   gen_i2c_addr, gen_wr_data     : latched request presented to the generator
//   gen_scl, gen_sda_out,
//   gen_sda_oe, gen_rd_data       : generator bus outputs and read data
module i2c_bus_arbiter
   import i2c_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        rnw0,
   input  logic        rnw1,
   input  logic [6:0]  addr0,
   input  logic [6:0]  addr1,
   input  logic [15:0] wr_data0,
   input  logic [15:0] wr_data1,
   output logic        grant0,
   output logic        grant1,
   output logic        done0,
   output logic        done1,
   output logic        err,
   output logic [15:0] rd_data,
   output logic        gen_start_stb,
   output logic        gen_rnw,
   output logic [6:0]  gen_i2c_addr,
   output logic [15:0] gen_wr_data,
   input  logic        gen_scl,
   input  logic        gen_sda_out,
   input  logic        gen_sda_oe,
   input  logic [15:0] gen_rd_data
);

   arb_state_e  state;
   logic        last_id;
   logic        cur_id;
   logic        sda_dly;
   logic [15:0] tmo_cnt;
   logic [15:0] tmo_inc;
   logic        tmo_hit;
   logic        start_det;
   logic        stop_det;
   logic        end_txn;
   logic        end_err;
   logic        pick_id;
   logic        pick_valid;

   i2c_rr_picker u_picker (
      .req0    (req0),
      .req1    (req1),
      .last_id (last_id),
      .winner  (pick_id),
      .valid   (pick_valid)
   );

   assign start_det = gen_sda_oe & gen_scl & ~gen_sda_out & sda_dly;
   assign stop_det  = gen_sda_oe & gen_scl & gen_sda_out & ~sda_dly;

   // The abort lands on the edge where the counter reaches TIMEOUT_CYCLES, so exactly
   // TIMEOUT_CYCLES cycles are spent waiting.
   assign tmo_inc = tmo_cnt + 16'd1;
   assign tmo_hit = (tmo_inc == TIMEOUT_CYCLES);

   // STOP outranks a coincident timeout; START never ends a transaction.
   always_comb begin
      end_txn = 1'b0;
      end_err = 1'b0;
      if (state == StWaitStop && stop_det) begin
         end_txn = 1'b1;
      end else if ((state == StWaitStart || state == StWaitStop) && tmo_hit) begin
         end_txn = 1'b1;
         end_err = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= StIdle;
         last_id       <= 1'b1;
         cur_id        <= 1'b0;
         sda_dly       <= 1'b1;
         tmo_cnt       <= 16'd0;
         grant0        <= 1'b0;
         grant1        <= 1'b0;
         done0         <= 1'b0;
         done1         <= 1'b0;
         err           <= 1'b0;
         rd_data       <= 16'd0;
         gen_start_stb <= 1'b0;
         gen_rnw       <= 1'b0;
         gen_i2c_addr  <= 7'd0;
         gen_wr_data   <= 16'd0;
      end else begin
         sda_dly <= gen_sda_out;
         case (state)
            StIdle: begin
               if (pick_valid) begin
                  state         <= StIssue;
                  cur_id        <= pick_id;
                  grant0        <= ~pick_id;
                  grant1        <= pick_id;
                  gen_start_stb <= 1'b1;
                  gen_rnw       <= pick_id ? rnw1 : rnw0;
                  gen_i2c_addr  <= pick_id ? addr1 : addr0;
                  gen_wr_data   <= pick_id ? wr_data1 : wr_data0;
               end
            end
            StIssue: begin
               gen_start_stb <= 1'b0;
               tmo_cnt       <= 16'd0;
               state         <= StWaitStart;
            end
            StWaitStart, StWaitStop: begin
               tmo_cnt <= tmo_inc;
               if (end_txn) begin
                  state <= StDone;
                  done0 <= ~cur_id;
                  done1 <= cur_id;
                  err   <= end_err;
                  if (gen_rnw) begin
                     rd_data <= gen_rd_data;
                  end
               end else if (state == StWaitStart && start_det) begin
                  state <= StWaitStop;
               end
            end
            StDone: begin
               done0   <= 1'b0;
               done1   <= 1'b0;
               grant0  <= 1'b0;
               grant1  <= 1'b0;
               last_id <= cur_id;
               state   <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
